// File: rtl/bsg_round_robin_n_to_n.sv
// bsg_round_robin_n_to_n: steers 0..lanes_p input elements into lanes_p FIFOs in strict round-robin order.
// Define BSG_ROUND_ROBIN_N_TO_N_COMPACT_EN to accept non-contiguous v_i, compacting valid lanes by rank.
module bsg_round_robin_n_to_n
  #(parameter int width_p = 8
   ,parameter int lanes_p = 4
   ,localparam int lg_lanes_lp = (lanes_p > 1) ? $clog2(lanes_p) : 1)
   (input  logic                         clk_i
   ,input  logic                         reset_n_i
   ,input  logic [width_p*lanes_p-1:0]   data_i
   ,input  logic [lanes_p-1:0]           v_i
   ,output logic [lanes_p-1:0]           ready_o
   ,output logic [width_p*lanes_p-1:0]   data_o
   ,output logic [lanes_p-1:0]           v_o
   ,input  logic [lanes_p-1:0]           ready_i
   ,input  logic                         sync_i
   ,output logic [lg_lanes_lp-1:0]       head_o
   );

    localparam logic [lg_lanes_lp:0] lanes_lp = (lg_lanes_lp+1)'(lanes_p);
    localparam logic [lg_lanes_lp:0] one_lp   = (lg_lanes_lp+1)'(1);

    logic [lg_lanes_lp-1:0] head_r;
    logic [lg_lanes_lp-1:0] out_idx;
    logic [lg_lanes_lp:0]   pos, out_sum, n_acc, head_sum;
    logic [lanes_p-1:0]     acc;
    logic                   chain;
`ifndef BSG_ROUND_ROBIN_N_TO_N_COMPACT_EN
    logic                   go;
`endif

    // pos is the round-robin slot offset from head: lane index, or rank when compacting
    always_comb begin
        ready_o = '0;
        v_o     = '0;
        data_o  = '0;
        acc     = '0;
        n_acc   = '0;
        pos     = '0;
        out_sum = '0;
        out_idx = '0;
        chain   = 1'b1;
`ifndef BSG_ROUND_ROBIN_N_TO_N_COMPACT_EN
        go      = 1'b1;
`endif
        for (int i = 0; i < lanes_p; i++) begin
            out_sum = {1'b0, head_r} + pos;
            out_idx = (out_sum >= lanes_lp) ? lg_lanes_lp'(out_sum - lanes_lp) : out_sum[lg_lanes_lp-1:0];
`ifdef BSG_ROUND_ROBIN_N_TO_N_COMPACT_EN
            if (v_i[i]) begin
                chain        = chain & ready_i[out_idx];
                ready_o[i]   = chain;
                acc[i]       = chain;
                v_o[out_idx] = chain;
                data_o[out_idx*width_p +: width_p] = data_i[i*width_p +: width_p];
                pos          = pos + one_lp;
            end
`else
            chain        = chain & ready_i[out_idx];
            ready_o[i]   = chain;
            go           = go & v_i[i] & chain;
            acc[i]       = go;
            v_o[out_idx] = go;
            data_o[out_idx*width_p +: width_p] = data_i[i*width_p +: width_p];
            pos          = pos + one_lp;
`endif
            n_acc = n_acc + (lg_lanes_lp+1)'(acc[i]);
        end
        if (!reset_n_i) begin
            ready_o = '0;
            v_o     = '0;
        end
    end

    assign head_sum = {1'b0, head_r} + n_acc;
    assign head_o   = head_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            head_r <= '0;
        else
            head_r <= sync_i ? '0
                    : (head_sum >= lanes_lp) ? lg_lanes_lp'(head_sum - lanes_lp) : head_sum[lg_lanes_lp-1:0];
    end

`ifndef BSG_HIDE_FROM_SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (lanes_p >= 2) else $error("lanes_p must be at least 2");
            assert ({1'b0, head_r} < lanes_lp) else $error("head_r out of range: %0d", head_r);
`ifndef BSG_ROUND_ROBIN_N_TO_N_COMPACT_EN
            if ((v_i & (v_i + lanes_p'(1))) != '0)
                $warning("v_i %b is not a contiguous prefix from lane 0", v_i);
`endif
        end
    end
`endif

endmodule
